// File: rtl/clock_ctrl_pkg.sv
// Shared types and rate decoding for the run/step clock-enable controller.
// Latency: combinational helpers only; no backpressure.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [1:0] RATE_DIV1  = 2'd0;
  localparam logic [1:0] RATE_DIV2  = 2'd1;
  localparam logic [1:0] RATE_SLOW  = 2'd2;
  localparam logic [1:0] RATE_VSLOW = 2'd3;

  // Divisors are carried at this width; the prescaler truncates to its own counter width.
  localparam int DIV_W = 32;

  function automatic logic [DIV_W-1:0] div_for(input logic [1:0]       rate_sel,
                                               input logic [DIV_W-1:0] div_slow,
                                               input logic [DIV_W-1:0] div_vslow);
    logic [DIV_W-1:0] div;
    div = DIV_W'(1);
    case (rate_sel)
      RATE_DIV1:  div = DIV_W'(1);
      RATE_DIV2:  div = DIV_W'(2);
      RATE_SLOW:  div = div_slow;
      RATE_VSLOW: div = div_vslow;
      default:    div = DIV_W'(1);
    endcase
    return div;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter; press is a one-cycle pulse on the accepted rising edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES before stable follows the button; no backpressure.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable_q <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_a   <= btn;
      sync_b   <= sync_a;
      stable_d <= stable_q;
      // Any return to the accepted level restarts the qualification window.
      if (sync_b == stable_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable_q <= sync_b;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign stable = stable_q;
  assign press  = stable_q & ~stable_d;

endmodule

// File: rtl/clock_step_controller.sv
// Run/step controller: one-cycle cpu_en pulses at a prescaled rate (free-run) or one per debounced press.
// Latency: cpu_en registered, first pulse 2 edges after RUN request, 1 edge after STEP; halt gates at once; no backpressure.
module clock_step_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W           = 28,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV_SLOW        = 65536,
  parameter int DIV_VSLOW       = 33554432
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        run_mode,
  input  logic [1:0]  rate_sel,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic        halted,
  output logic [3:0]  state_led,
  output logic [15:0] tick_count
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] div_m1;
  logic [DIV_W-1:0] div_full;
  logic [1:0]       rate_q;
  logic             tick;
  logic             rate_chg;
  logic             enter_run;
  logic             cpu_en_nxt;
  logic             btn_stable;
  logic             btn_press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock_50 (clock_50),
    .reset    (reset),
    .btn      (step_btn),
    .stable   (btn_stable),
    .press    (btn_press)
  );

  assign div_full  = div_for(rate_sel, DIV_W'(DIV_SLOW), DIV_W'(DIV_VSLOW)) - DIV_W'(1);
  assign div_m1    = div_full[CNT_W-1:0];
  assign tick      = (pre_cnt == div_m1);
  assign rate_chg  = (rate_sel != rate_q);
  assign enter_run = (state != RUN) && (state_nxt == RUN);

  // Restarting on a rate change or RUN entry makes the first tick land a full period later.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      pre_cnt <= '0;
      rate_q  <= rate_sel;
    end else begin
      rate_q <= rate_sel;
      if (rate_chg || enter_run || tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HALTED: begin
        if (halt) begin
          state_nxt = HALTED;
        end else if (run_mode) begin
          state_nxt = RUN;
        end else if (btn_press) begin
          state_nxt = STEP;
        end
      end
      RUN: begin
        if (halt || !run_mode) begin
          state_nxt = HALTED;
        end
      end
      STEP:     state_nxt = WAIT_REL;
      WAIT_REL: begin
        if (!btn_stable) begin
          state_nxt = HALTED;
        end
      end
      default:  state_nxt = HALTED;
    endcase
    cpu_en_nxt = ((state == RUN) && tick && !halt && run_mode) || (state == STEP);
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= HALTED;
      cpu_en     <= 1'b0;
      tick_count <= '0;
    end else begin
      state  <= state_nxt;
      cpu_en <= cpu_en_nxt;
      // Counted alongside the pulse so tick_count always includes the pulse on cpu_en.
      if (cpu_en_nxt) begin
        tick_count <= tick_count + 16'd1;
      end
    end
  end

  assign halted = (state == HALTED);

  always_comb begin
    state_led = 4'b0000;
    case (state)
      HALTED:   state_led = 4'b0001;
      RUN:      state_led = 4'b0010;
      STEP:     state_led = 4'b0100;
      WAIT_REL: state_led = 4'b1000;
      default:  state_led = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Bench for clock_step_controller: expected cpu_en pulse cycles are queued with the stimulus
// and compared against pulses captured by a monitor, plus direct state/counter checks.
module tb_clock_step_controller;

  logic        clock_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        run_mode = 1'b1;
  logic [1:0]  rate_sel = 2'd0;
  logic        step_btn = 1'b0;
  logic        halt     = 1'b0;
  logic        cpu_en;
  logic        halted;
  logic [3:0]  state_led;
  logic [15:0] tick_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b1;
  int exp_q[$];
  int obs_q[$];

  always #5 clock_50 = ~clock_50;

  clock_step_controller #(
    .CNT_W           (28),
    .DEBOUNCE_CYCLES (4),
    .DIV_SLOW        (8),
    .DIV_VSLOW       (16)
  ) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .run_mode   (run_mode),
    .rate_sel   (rate_sel),
    .step_btn   (step_btn),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .state_led  (state_led),
    .tick_count (tick_count)
  );

  // Edge counter and pulse capture, sampled 1 time unit after each rising edge.
  always @(posedge clock_50) begin
    cyc++;
    #1;
    if (mon_en && cpu_en) obs_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after an edge, after the monitor has sampled.
  task automatic step(input int n);
    repeat (n) @(posedge clock_50);
    #2;
  endtask

  task automatic expect_pulses(input int first, input int last, input int stride);
    for (int c = first; c <= last; c += stride) exp_q.push_back(c);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_cycle"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          b;
    logic [15:0] tc1;

    // Reset state
    reset = 1'b1; run_mode = 1'b1; step(3);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_led", 32'(state_led), 32'h1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_tick_count", 32'(tick_count), 32'd0);

    // Free-run at div1: pulses from the 2nd edge after release
    b = cyc; reset = 1'b0; step(20);
    expect_pulses(b + 2, b + 20, 1);
    drain("div1");
    chk("div1_tick_count", 32'(tick_count), 32'd19);
    chk("run_led", 32'(state_led), 32'h2);

    // Switch to DIV_SLOW=8: first pulse a full period after the change
    b = cyc; rate_sel = 2'd2; step(30);
    expect_pulses(b + 9, b + 25, 8);
    drain("div8");

    // Single-step mode with a 1-cycle glitch first
    run_mode = 1'b0; rate_sel = 2'd0; step(3);
    chk("step_mode_halted", 32'(halted), 32'd1);
    drain("mode_switch");
    step_btn = 1'b1; step(1); step_btn = 1'b0; step(8);
    chk("glitch_led", 32'(state_led), 32'h1);
    drain("glitch");

    tc1 = tick_count + 16'd1;
    b = cyc; step_btn = 1'b1; step(7);
    chk("step_led", 32'(state_led), 32'h4);
    step(1);
    chk("wait_led", 32'(state_led), 32'h8);
    chk("step_cpu_en", 32'(cpu_en), 32'd1);
    step(2); step_btn = 1'b0; step(10);
    chk("release_led", 32'(state_led), 32'h1);
    exp_q.push_back(b + 8);
    drain("step");
    chk("step_tick_count", 32'(tick_count), 32'(tc1));

    // Long hold with a run_mode toggle during WAIT_REL
    tc1 = tick_count + 16'd1;
    b = cyc; step_btn = 1'b1; step(20);
    run_mode = 1'b1; step(5);
    chk("wait_ignores_mode", 32'(state_led), 32'h8);
    run_mode = 1'b0; step(25);
    step_btn = 1'b0; step(12);
    exp_q.push_back(b + 8);
    drain("hold");
    chk("hold_tick_count", 32'(tick_count), 32'(tc1));
    chk("hold_led", 32'(state_led), 32'h1);

    // Halt during RUN at div1, then resume
    b = cyc; run_mode = 1'b1; step(5);
    halt = 1'b1; step(1);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);
    step(4);
    chk("halt_hold_led", 32'(state_led), 32'h1);
    halt = 1'b0; step(5);
    chk("resume_led", 32'(state_led), 32'h2);
    expect_pulses(b + 2, b + 5, 1);
    expect_pulses(b + 12, b + 15, 1);
    drain("halt");

    // Press while halt is asserted is discarded
    run_mode = 1'b0; step(2);
    halt = 1'b1; step_btn = 1'b1; step(15);
    halt = 1'b0; step(5);
    chk("halt_press_led", 32'(state_led), 32'h1);
    step_btn = 1'b0; step(10);
    chk("halt_press_halted", 32'(halted), 32'd1);
    drain("halt_press");

    // Reset during STEP
    step_btn = 1'b1; step(7);
    chk("pre_rst_step_led", 32'(state_led), 32'h4);
    reset = 1'b1; step_btn = 1'b0; step(1);
    chk("rst_step_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_step_led", 32'(state_led), 32'h1);
    reset = 1'b0; step(2);
    drain("rst_step");

    // Reset during RUN
    b = cyc; run_mode = 1'b1; step(5);
    reset = 1'b1; step(1);
    chk("rst_run_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_run_led", 32'(state_led), 32'h1);
    chk("rst_run_tick_count", 32'(tick_count), 32'd0);
    expect_pulses(b + 2, b + 5, 1);
    drain("rst_run");

    // tick_count wrap: 65535 pulses then one more
    mon_en = 1'b0;
    reset = 1'b0; step(65536);
    chk("wrap_pre", 32'(tick_count), 32'hFFFF);
    chk("wrap_pre_cpu_en", 32'(cpu_en), 32'd1);
    step(1);
    chk("wrap", 32'(tick_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
